// File: rtl/kontroler_przerwan.sv
// Fixed-priority vectored interrupt controller: edge-captures source pulses into
// pending bits, masks them, and hands one request at a time to the CPU (no nesting).
module kontroler_przerwan #(
    parameter int          N_ZRODEL = 4,
    parameter logic [7:0]  VEC_BASE = 8'h04,
    parameter logic [7:0]  VEC_STEP = 8'h04
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_ZRODEL-1:0] zrodla,
    input  logic [7:0]          wartosc,
    input  logic                zapisz_maska,
    input  logic                zapisz_clr,
    input  logic                int_ack,
    input  logic                int_done,
    output logic                int_req,
    output logic [7:0]          int_vector,
    output logic [N_ZRODEL-1:0] oczekujace,
    output logic                w_obsludze
);

    // Handshake: int_req stays high with a stable int_vector until int_ack is
    // sampled high on a rising edge; int_done ends the service period.
    typedef enum logic [1:0] {IDLE, ZGLOSZENIE, OBSLUGA} stan_t;

    stan_t               stan_q, stan_d;
    logic [N_ZRODEL-1:0] maska_q, maska_d;
    logic [N_ZRODEL-1:0] pending_q, pending_d;
    logic [N_ZRODEL-1:0] prev_q;
    logic                global_en_q, global_en_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          vector_q, vector_d;

    logic [N_ZRODEL-1:0] narastanie;
    logic [N_ZRODEL-1:0] eligible;
    logic [N_ZRODEL-1:0] idx_onehot;
    logic [N_ZRODEL-1:0] kasuj;
    logic [2:0]          wybor;
    logic                jest_wybor;
    logic                latched_ok;
    logic                ack_ok;
    logic                unused_wartosc;

    assign unused_wartosc = ^wartosc;

    always_comb begin
        narastanie = zrodla & ~prev_q;
        eligible   = global_en_q ? (pending_q & maska_q) : '0;
        jest_wybor = |eligible;
        wybor      = '0;
        // Scan from the top so the lowest eligible index is the one left standing.
        for (int i = N_ZRODEL - 1; i >= 0; i--) begin
            if (eligible[i]) wybor = 3'(i);
        end
        for (int i = 0; i < N_ZRODEL; i++) begin
            idx_onehot[i] = (idx_q == 3'(i));
        end
        latched_ok = |(eligible & idx_onehot);
        ack_ok     = (stan_q == ZGLOSZENIE) && int_ack;
        kasuj      = (zapisz_clr ? wartosc[N_ZRODEL-1:0] : '0)
                   | (ack_ok ? idx_onehot : '0);
        // A fresh edge beats any clear in the same cycle.
        pending_d  = (pending_q & ~kasuj) | narastanie;
        maska_d     = zapisz_maska ? wartosc[N_ZRODEL-1:0] : maska_q;
        global_en_d = zapisz_maska ? wartosc[7] : global_en_q;
    end

    always_comb begin
        stan_d   = stan_q;
        idx_d    = idx_q;
        vector_d = vector_q;
        case (stan_q)
            IDLE: begin
                if (jest_wybor) begin
                    stan_d   = ZGLOSZENIE;
                    idx_d    = wybor;
                    vector_d = VEC_BASE + 8'(wybor) * VEC_STEP;
                end
            end
            ZGLOSZENIE: begin
                if (ack_ok) begin
                    stan_d = OBSLUGA;
                end else if (!latched_ok) begin
                    stan_d = IDLE;
                end
            end
            OBSLUGA: begin
                if (int_done) stan_d = IDLE;
            end
            default: stan_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stan_q      <= IDLE;
            maska_q     <= '0;
            global_en_q <= 1'b0;
            pending_q   <= '0;
            prev_q      <= '0;
            idx_q       <= '0;
            vector_q    <= '0;
        end else begin
            stan_q      <= stan_d;
            maska_q     <= maska_d;
            global_en_q <= global_en_d;
            pending_q   <= pending_d;
            prev_q      <= zrodla;
            idx_q       <= idx_d;
            vector_q    <= vector_d;
        end
    end

    assign int_req    = (stan_q == ZGLOSZENIE);
    assign int_vector = int_req ? vector_q : 8'h00;
    assign w_obsludze = (stan_q == OBSLUGA);
    assign oczekujace = pending_q;

endmodule

// File: tb/tb_kontroler_przerwan.sv
// Bench for kontroler_przerwan: directed scenarios plus random traffic, every
// cycle checked against a reference model through an expected-output queue.
module tb_kontroler_przerwan;

    localparam int N = 4;
    localparam int W = 10 + N;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] zrodla;
    logic [7:0]   wartosc;
    logic         zapisz_maska;
    logic         zapisz_clr;
    logic         int_ack;
    logic         int_done;
    logic         int_req;
    logic [7:0]   int_vector;
    logic [N-1:0] oczekujace;
    logic         w_obsludze;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    kontroler_przerwan #(
        .N_ZRODEL(N),
        .VEC_BASE(8'h04),
        .VEC_STEP(8'h04)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .zrodla      (zrodla),
        .wartosc     (wartosc),
        .zapisz_maska(zapisz_maska),
        .zapisz_clr  (zapisz_clr),
        .int_ack     (int_ack),
        .int_done    (int_done),
        .int_req     (int_req),
        .int_vector  (int_vector),
        .oczekujace  (oczekujace),
        .w_obsludze  (w_obsludze)
    );

    // Reference model: phase 0 = nothing offered, 1 = request offered, 2 = in service.
    bit m_pend[N];
    bit m_mask[N];
    bit m_prev[N];
    int m_gen   = 0;
    int m_phase = 0;
    int m_src   = 0;
    int m_vec   = 0;

    always @(posedge clk) begin
        bit           np[N];
        int           best;
        logic [N-1:0] pv;
        logic [7:0]   ev;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0;
            end
            m_gen = 0; m_phase = 0; m_src = 0; m_vec = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (zrodla[i] && !m_prev[i])
                    np[i] = 1;
                else if ((zapisz_clr && wartosc[i]) || (m_phase == 1 && int_ack && m_src == i))
                    np[i] = 0;
                else
                    np[i] = m_pend[i];
            end
            case (m_phase)
                0: begin
                    best = -1;
                    for (int i = 0; i < N; i++)
                        if (best < 0 && m_gen != 0 && m_mask[i] && m_pend[i]) best = i;
                    if (best >= 0) begin
                        m_phase = 1;
                        m_src   = best;
                        m_vec   = (4 + 4 * best) % 256;
                    end
                end
                1: begin
                    if (int_ack) m_phase = 2;
                    else if (!(m_gen != 0 && m_mask[m_src] && m_pend[m_src])) m_phase = 0;
                end
                default: begin
                    if (int_done) m_phase = 0;
                end
            endcase
            for (int i = 0; i < N; i++) begin
                m_pend[i] = np[i];
                m_prev[i] = zrodla[i];
                if (zapisz_maska) m_mask[i] = wartosc[i];
            end
            if (zapisz_maska) m_gen = wartosc[7] ? 1 : 0;
        end
        for (int i = 0; i < N; i++) pv[i] = m_pend[i];
        ev = (m_phase == 1) ? 8'(m_vec) : 8'h00;
        exp_q.push_back({(m_phase == 1), ev, (m_phase == 2), pv});
    end

    // Monitor: compare the DUT outputs against the oldest expectation, mid-cycle.
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {int_req, int_vector, w_obsludze, oczekujace};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL scoreboard t=%0t act req=%b vec=%h srv=%b pend=%b exp req=%b vec=%h srv=%b pend=%b",
                         $time, a[W-1], a[W-2:W-9], a[N], a[N-1:0],
                         e[W-1], e[W-2:W-9], e[N], e[N-1:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic write_mask(input logic [7:0] v);
        wartosc = v; zapisz_maska = 1'b1;
        tick();
        zapisz_maska = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] z);
        zrodla = z;
        tick();
        zrodla = '0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!int_req && n < 12) begin
            tick();
            n++;
        end
        check(name, {31'd0, int_req}, 32'd1);
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; zrodla = '0; wartosc = '0; zapisz_maska = 1'b0;
        zapisz_clr = 1'b0; int_ack = 1'b0; int_done = 1'b0;
        tick(); tick();
        check("reset_outputs", {18'd0, int_req, int_vector, w_obsludze, oczekujace}, 32'd0);
        rst = 1'b0;

        // Basic single service of source 0.
        write_mask(8'h81);
        pulse(4'b0001);
        check("pend_t1", {28'd0, oczekujace}, 32'h1);
        check("req_t1", {31'd0, int_req}, 32'd0);
        tick();
        check("req_t2", {31'd0, int_req}, 32'd1);
        check("vec_src0", {24'd0, int_vector}, 32'h04);
        ack();
        check("ack_req_low", {31'd0, int_req}, 32'd0);
        check("ack_srv", {31'd0, w_obsludze}, 32'd1);
        check("ack_pend", {28'd0, oczekujace}, 32'h0);
        done();
        check("done_srv", {31'd0, w_obsludze}, 32'd0);

        // Two simultaneous sources: lower index first, next at least 2 cycles after done.
        write_mask(8'h8F);
        pulse(4'b0110);
        wait_req("req_pair1");
        check("vec_pair1", {24'd0, int_vector}, 32'h08);
        ack();
        done();
        check("gap_after_done", {31'd0, int_req}, 32'd0);
        wait_req("req_pair2");
        check("vec_pair2", {24'd0, int_vector}, 32'h0C);
        ack();
        done();

        // No re-arbitration while a request is offered.
        pulse(4'b1000);
        wait_req("req_src3");
        pulse(4'b0001);
        tick();
        check("vec_held", {24'd0, int_vector}, 32'h10);
        ack();
        done();
        wait_req("req_src0_after");
        check("vec_src0_after", {24'd0, int_vector}, 32'h04);
        ack();
        done();

        // Global enable off: pending latches but no request until enabled.
        write_mask(8'h01);
        pulse(4'b0001);
        tick(); tick();
        check("glob_off_req", {31'd0, int_req}, 32'd0);
        check("glob_off_pend", {28'd0, oczekujace}, 32'h1);
        write_mask(8'h81);
        check("glob_on_req_w1", {31'd0, int_req}, 32'd0);
        tick();
        check("glob_on_req_w2", {31'd0, int_req}, 32'd1);
        ack();
        done();

        // Withdrawal by masking, then software clear.
        write_mask(8'h8F);
        pulse(4'b0010);
        wait_req("req_src1");
        check("vec_src1", {24'd0, int_vector}, 32'h08);
        write_mask(8'h80);
        tick();
        check("withdraw_req", {31'd0, int_req}, 32'd0);
        check("withdraw_pend", {28'd0, oczekujace}, 32'h2);
        wartosc = 8'h02; zapisz_clr = 1'b1;
        tick();
        zapisz_clr = 1'b0;
        check("clr_pend", {28'd0, oczekujace}, 32'h0);

        // Held level captures once; reset during service clears everything.
        write_mask(8'h81);
        zrodla = 4'b0001;
        tick(); tick();
        check("hold_req", {31'd0, int_req}, 32'd1);
        ack();
        for (int i = 0; i < 7; i++) tick();
        check("hold_pend", {28'd0, oczekujace}, 32'h0);
        check("hold_no_req", {31'd0, int_req}, 32'd0);
        check("hold_srv", {31'd0, w_obsludze}, 32'd1);
        zrodla = '0;
        rst = 1'b1;
        tick();
        check("rst_mid", {18'd0, int_req, int_vector, w_obsludze, oczekujace}, 32'd0);
        rst = 1'b0;

        // Random traffic.
        write_mask(8'h8F);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) zrodla[i] = ($urandom_range(0, 5) == 0);
            int_ack  = int_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            int_done = w_obsludze ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            zapisz_maska = ($urandom_range(0, 19) == 0);
            zapisz_clr   = ($urandom_range(0, 24) == 0);
            wartosc = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) wartosc[7] = 1'b1;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; zrodla = '0; int_ack = 1'b0; int_done = 1'b0;
        zapisz_maska = 1'b0; zapisz_clr = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kontroler_przerwan.md
Name: kontroler_przerwan

Overview:
- Fixed-priority interrupt controller directly downstream of the 16-bit timer (licznik) and the other peripheral interrupt sources.
- Latches single-cycle interrupt pulses (source 0 is licznik_int) into pending bits and applies per-source and global masking.
- Presents one vectored request at a time to the CPU core, tracks it through the acknowledge/return handshake, and blocks further requests until the current one finishes. No nesting.

Parameters:
- N_ZRODEL, 4, number of interrupt sources, legal range 1..7; bit index equals priority, with 0 highest.
- VEC_BASE, 8'h04, vector address of source 0.
- VEC_STEP, 8'h04, vector spacing between consecutive sources.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- zrodla  in  N_ZRODEL  interrupt source lines; bit 0 = licznik_int.
- wartosc  in  8  CPU write data bus.
- zapisz_maska  in  1  write control register: maska <= wartosc[N_ZRODEL-1:0], global_en <= wartosc[7].
- zapisz_clr  in  1  write-1-to-clear of pending bits selected by wartosc[N_ZRODEL-1:0].
- int_ack  in  1  CPU accepts the current request; vector is consumed this cycle.
- int_done  in  1  CPU executed return-from-interrupt.
- int_req  out  1  interrupt request to the CPU core.
- int_vector  out  8  ISR address; valid and stable while int_req=1.
- oczekujace  out  N_ZRODEL  pending bits, for polling readback.
- w_obsludze  out  1  an ISR is in service.

Behaviour:
- Reset: maska=0, global_en=0, pending=0, edge-detect history=0, state=IDLE.
  - int_req=0, int_vector=8'h00, w_obsludze=0, oczekujace=0.
  - Reset mid-handshake aborts immediately; no request survives.
- Source capture:
  - Rising edge of zrodla[i] (current=1, previous cycle=0) sets pending[i] on the next clock.
  - A level held high sets pending only once.
  - Capture is independent of the mask: masked sources still latch pending.
- Pending clear:
  - Bit i clears on int_ack while i is the selected source, or on zapisz_clr with wartosc[i]=1.
  - A new edge on the same bit in the same cycle wins: the bit stays set.
- oczekujace mirrors the pending register directly.
- Eligible set = pending & maska when global_en=1; otherwise empty.
- Selection: lowest index in the eligible set.
- Vector arithmetic: int_vector = VEC_BASE + idx*VEC_STEP, modulo 256.
- FSM states: IDLE, ZGLOSZENIE, OBSLUGA.
- IDLE:
  - If the eligible set is non-empty: latch idx and vector, go to ZGLOSZENIE.
  - int_req=1 from the next cycle.
- ZGLOSZENIE:
  - int_req=1 and int_vector held stable. A higher-priority arrival does not change the latched request (no re-arbitration).
  - int_ack=1: clear pending[idx], go to OBSLUGA. Next cycle int_req=0 and w_obsludze=1.
  - Latched source no longer eligible (masked, global_en=0, or its pending cleared by zapisz_clr) with no ack this cycle: withdraw to IDLE, int_req=0 next cycle.
  - Ack wins over a simultaneous withdrawal.
- OBSLUGA:
  - w_obsludze=1, int_req=0. New pulses still latch pending.
  - int_done=1: go to IDLE, w_obsludze=0 next cycle.
  - Re-arbitration happens in IDLE, so the next int_req is at least 2 cycles after int_done.
- Ignored inputs: int_ack outside ZGLOSZENIE; int_done outside OBSLUGA.
- Latency:
  - Source edge at cycle t → pending at t+1 → int_req at t+2 (from IDLE, source eligible).
  - int_ack at t → int_req low and w_obsludze high at t+1.
- Register writes: zapisz_maska and zapisz_clr take effect on the next clock. If both are asserted, both apply.

Test Plan:
- Reset, write maska=8'h81 (source 0 enabled, global on), pulse zrodla[0] one cycle at t → pending[0]=1 at t+1, int_req=1 with int_vector=8'h04 at t+2; int_ack → int_req=0, w_obsludze=1, oczekujace=0; int_done → w_obsludze=0.
- Enable sources 0..3, pulse zrodla[2] and zrodla[1] in the same cycle → vector 8'h08 served first; after int_done the next request appears ≥2 cycles later with vector 8'h0C.
- Request for source 3 pending in ZGLOSZENIE, pulse source 0 → int_vector stays 8'h10 until ack; source 0 (8'h04) is served after int_done.
- maska=8'h01 (global off), pulse source 0 → pending[0]=1, int_req stays 0; then write maska=8'h81 → int_req=1 two cycles after the write.
- In ZGLOSZENIE for source 1, write maska=8'h80 → int_req=0 next cycle, pending[1] still 1; zapisz_clr with wartosc=8'h02 → oczekujace=0.
- Hold zrodla[0] high for 10 cycles → one pending set and one service only; assert rst while in OBSLUGA → all outputs 0 next cycle.
